// File: rtl/jtag_dtm_tap_if.sv
// Debug-module request/response port between the DTM (master) and the debug module (slave).
// Both directions use valid/ready; a transfer completes on a rising edge with valid&ready.
interface jtag_dtm_tap_if #(
  parameter int ABITS    = 5,
  parameter int DR_WIDTH = ABITS + 36
);
  logic                dtm_req_valid;
  logic                dtm_req_ready;
  logic [DR_WIDTH-1:0] dtm_req_bits;
  logic                dtm_resp_valid;
  logic                dtm_resp_ready;
  logic [35:0]         dtm_resp_bits;

  modport master (
    output dtm_req_valid, dtm_req_bits, dtm_resp_ready,
    input  dtm_req_ready, dtm_resp_valid, dtm_resp_bits
  );

  modport slave (
    input  dtm_req_valid, dtm_req_bits, dtm_resp_ready,
    output dtm_req_ready, dtm_resp_valid, dtm_resp_bits
  );
endinterface

// File: rtl/jtag_dtm_tap.sv
// JTAG TAP + RISC-V DTM: scans IR/DR on TCK; a DEBUG_ACCESS Update-DR raises a request one cycle later,
// held until dtm_req_ready; the response is taken in WAIT and scans meanwhile report busy (op=3).
module jtag_dtm_tap #(
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_0001,
  parameter int          ABITS        = 5,
  parameter int          DR_WIDTH     = ABITS + 36
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            tms,
  input  logic            tdi,
  output logic            tdo,
  output logic            tdo_en,
  jtag_dtm_tap_if.master  dmi
);

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'h0, RUN_TEST_IDLE = 4'h1, SELECT_DR = 4'h2, CAPTURE_DR = 4'h3,
    SHIFT_DR         = 4'h4, EXIT1_DR      = 4'h5, PAUSE_DR  = 4'h6, EXIT2_DR   = 4'h7,
    UPDATE_DR        = 4'h8, SELECT_IR     = 4'h9, CAPTURE_IR = 4'hA, SHIFT_IR  = 4'hB,
    EXIT1_IR         = 4'hC, PAUSE_IR      = 4'hD, EXIT2_IR  = 4'hE, UPDATE_IR  = 4'hF
  } tap_state_t;

  typedef enum logic [1:0] {REQ_IDLE, REQ_REQ, REQ_WAIT} req_state_t;
  typedef enum logic [1:0] {SEL_IDCODE, SEL_DTM_INFO, SEL_DMI, SEL_BYPASS} dr_sel_t;

  localparam logic [4:0] IR_IDCODE   = 5'b00001;
  localparam logic [4:0] IR_DTM_INFO = 5'b10000;
  localparam logic [4:0] IR_DMI      = 5'b10001;

  tap_state_t          tap_state;
  req_state_t          req_state;
  logic [4:0]          ir;
  logic [4:0]          ir_shift;
  logic [DR_WIDTH-1:0] dr_shift;
  logic                sticky_busy;
  logic [ABITS-1:0]    last_addr;
  logic [33:0]         resp_data;
  logic [1:0]          resp_code;

  dr_sel_t             dr_sel;
  logic                in_flight;
  logic [1:0]          cap_op;
  logic [1:0]          upd_op;
  logic [DR_WIDTH-1:0] dr_capture;
  logic [DR_WIDTH-1:0] dr_shifted;

  assign in_flight = (req_state != REQ_IDLE);
  assign cap_op    = (sticky_busy || in_flight) ? 2'd3 : resp_code;
  assign upd_op    = dr_shift[1:0];

  always_comb begin
    dr_sel = SEL_BYPASS;
    case (ir)
      IR_IDCODE:   dr_sel = SEL_IDCODE;
      IR_DTM_INFO: dr_sel = SEL_DTM_INFO;
      IR_DMI:      dr_sel = SEL_DMI;
      default:     dr_sel = SEL_BYPASS;
    endcase
  end

  // tdi always enters at the MSB of the selected register's own length.
  always_comb begin
    dr_capture = '0;
    dr_shifted = '0;
    case (dr_sel)
      SEL_IDCODE: begin
        dr_capture = {{(DR_WIDTH-32){1'b0}}, IDCODE_VALUE};
        dr_shifted = {{(DR_WIDTH-32){1'b0}}, tdi, dr_shift[31:1]};
      end
      SEL_DTM_INFO: begin
        dr_capture = {{(DR_WIDTH-32){1'b0}}, 20'b0, (sticky_busy ? 2'd3 : 2'd0), 6'(ABITS), 4'h1};
        dr_shifted = {{(DR_WIDTH-32){1'b0}}, tdi, dr_shift[31:1]};
      end
      SEL_DMI: begin
        dr_capture = {last_addr, resp_data, cap_op};
        dr_shifted = {tdi, dr_shift[DR_WIDTH-1:1]};
      end
      default: begin
        dr_capture = '0;
        dr_shifted = {{(DR_WIDTH-1){1'b0}}, tdi};
      end
    endcase
  end

  assign tdo_en = (tap_state == SHIFT_DR) || (tap_state == SHIFT_IR);
  assign tdo    = (tap_state == SHIFT_DR) ? dr_shift[0] :
                  (tap_state == SHIFT_IR) ? ir_shift[0] : 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tap_state          <= TEST_LOGIC_RESET;
      req_state          <= REQ_IDLE;
      ir                 <= IR_IDCODE;
      ir_shift           <= '0;
      dr_shift           <= '0;
      sticky_busy        <= 1'b0;
      last_addr          <= '0;
      resp_data          <= '0;
      resp_code          <= '0;
      dmi.dtm_req_valid  <= 1'b0;
      dmi.dtm_req_bits   <= '0;
      dmi.dtm_resp_ready <= 1'b0;
    end else begin
      case (tap_state)
        TEST_LOGIC_RESET: tap_state <= tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    tap_state <= tms ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_DR:        tap_state <= tms ? SELECT_IR : CAPTURE_DR;
        CAPTURE_DR:       tap_state <= tms ? EXIT1_DR : SHIFT_DR;
        SHIFT_DR:         tap_state <= tms ? EXIT1_DR : SHIFT_DR;
        EXIT1_DR:         tap_state <= tms ? UPDATE_DR : PAUSE_DR;
        PAUSE_DR:         tap_state <= tms ? EXIT2_DR : PAUSE_DR;
        EXIT2_DR:         tap_state <= tms ? UPDATE_DR : SHIFT_DR;
        UPDATE_DR:        tap_state <= tms ? SELECT_DR : RUN_TEST_IDLE;
        SELECT_IR:        tap_state <= tms ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       tap_state <= tms ? EXIT1_IR : SHIFT_IR;
        SHIFT_IR:         tap_state <= tms ? EXIT1_IR : SHIFT_IR;
        EXIT1_IR:         tap_state <= tms ? UPDATE_IR : PAUSE_IR;
        PAUSE_IR:         tap_state <= tms ? EXIT2_IR : PAUSE_IR;
        EXIT2_IR:         tap_state <= tms ? UPDATE_IR : SHIFT_IR;
        default:          tap_state <= tms ? SELECT_DR : RUN_TEST_IDLE;
      endcase

      case (req_state)
        REQ_REQ: if (dmi.dtm_req_ready) begin
          dmi.dtm_req_valid  <= 1'b0;
          dmi.dtm_resp_ready <= 1'b1;
          req_state          <= REQ_WAIT;
        end
        REQ_WAIT: if (dmi.dtm_resp_valid) begin
          resp_data          <= dmi.dtm_resp_bits[35:2];
          resp_code          <= dmi.dtm_resp_bits[1:0];
          dmi.dtm_resp_ready <= 1'b0;
          req_state          <= REQ_IDLE;
        end
        default: ;
      endcase

      case (tap_state)
        TEST_LOGIC_RESET: begin
          ir          <= IR_IDCODE;
          sticky_busy <= 1'b0;
        end
        CAPTURE_IR: ir_shift <= 5'b00001;
        SHIFT_IR:   ir_shift <= {tdi, ir_shift[4:1]};
        UPDATE_IR:  ir       <= ir_shift;
        CAPTURE_DR: dr_shift <= dr_capture;
        SHIFT_DR:   dr_shift <= dr_shifted;
        UPDATE_DR: begin
          // An access that collides with an outstanding one is lost; sticky_busy records that.
          if (dr_sel == SEL_DMI) begin
            if (in_flight) begin
              sticky_busy <= 1'b1;
            end else if (!sticky_busy && (upd_op == 2'd1 || upd_op == 2'd2)) begin
              dmi.dtm_req_bits  <= dr_shift;
              dmi.dtm_req_valid <= 1'b1;
              last_addr         <= dr_shift[DR_WIDTH-1 -: ABITS];
              req_state         <= REQ_REQ;
            end
          end else if (dr_sel == SEL_DTM_INFO && dr_shift[16]) begin
            sticky_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_dtm_tap.sv
// Bench for jtag_dtm_tap: table of IR/DR scans plus hand sequences for the debug-access handshake,
// sticky busy, and asynchronous reset; expected scan results go through a scoreboard queue.
module tb_jtag_dtm_tap;

  logic clk = 1'b0;
  logic reset_n;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_en;

  jtag_dtm_tap_if #(.ABITS(5)) dmi ();

  jtag_dtm_tap #(.IDCODE_VALUE(32'h1000_0001), .ABITS(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .tms     (tms),
    .tdi     (tdi),
    .tdo     (tdo),
    .tdo_en  (tdo_en),
    .dmi     (dmi.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] sb_q[$];

  typedef struct {
    logic [4:0]  ir;
    int          len;
    logic [63:0] din;
    logic [63:0] exp_dr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dmi_word(input logic [4:0] a, input logic [33:0] d, input logic [1:0] op);
    return {23'b0, a, d, op};
  endfunction

  // Called at a falling edge; tdo is sampled there, before the rising edge consumes tms/tdi.
  task automatic step(input logic t, input logic d, output logic o);
    tms = t;
    tdi = d;
    o   = tdo;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic go_idle();
    logic o;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, o);
    step(1'b0, 1'b0, o);
  endtask

  task automatic shift_ir(input logic [4:0] code, output logic [4:0] cap);
    logic o;
    step(1'b1, 1'b0, o);
    step(1'b1, 1'b0, o);
    step(1'b0, 1'b0, o);
    step(1'b0, 1'b0, o);
    for (int i = 0; i < 5; i++) begin
      step(i == 4, code[i], o);
      cap[i] = o;
    end
    step(1'b1, 1'b0, o);
    step(1'b0, 1'b0, o);
  endtask

  task automatic scan_dr(input int n, input logic [63:0] din, output logic [63:0] dout);
    logic o;
    dout = '0;
    step(1'b1, 1'b0, o);
    step(1'b0, 1'b0, o);
    step(1'b0, 1'b0, o);
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], o);
      dout[i] = o;
    end
    step(1'b1, 1'b0, o);
    step(1'b0, 1'b0, o);
  endtask

  task automatic expect_scan(input string name, input int n, input logic [63:0] din, input logic [63:0] exp);
    logic [63:0] dout;
    sb_q.push_back(exp);
    scan_dr(n, din, dout);
    check(name, dout, sb_q.pop_front());
  endtask

  task automatic ir_to(input logic [4:0] code);
    logic [4:0] cap;
    shift_ir(code, cap);
    check("ir_capture", 64'(cap), 64'(5'b00001));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic o;
    logic [4:0] cap;

    vecs[0] = '{5'b00001, 32, 64'h0,    64'h1000_0001};
    vecs[1] = '{5'b10000, 32, 64'h0,    64'h0000_0051};
    vecs[2] = '{5'b11111, 8,  64'hA5,   64'h4A};
    vecs[3] = '{5'b00101, 8,  64'h3C,   64'h78};
    vecs[4] = '{5'b00001, 32, 64'hFFFF, 64'h1000_0001};

    reset_n = 1'b0;
    tms = 1'b1;
    tdi = 1'b0;
    dmi.dtm_req_ready  = 1'b0;
    dmi.dtm_resp_valid = 1'b0;
    dmi.dtm_resp_bits  = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_tdo", 64'(tdo), 0);
    check("rst_tdo_en", 64'(tdo_en), 0);
    check("rst_req_valid", 64'(dmi.dtm_req_valid), 0);
    check("rst_req_bits", 64'(dmi.dtm_req_bits), 0);
    check("rst_resp_ready", 64'(dmi.dtm_resp_ready), 0);
    check("rst_tap_state", 64'(4'(dut.tap_state)), 0);
    reset_n = 1'b1;

    go_idle();
    check("idle_state", 64'(4'(dut.tap_state)), 1);
    expect_scan("default_idcode", 32, 64'h0, 64'h1000_0001);

    for (int i = 0; i < 5; i++) begin
      ir_to(vecs[i].ir);
      expect_scan($sformatf("vec%0d_dr", i), vecs[i].len, vecs[i].din, vecs[i].exp_dr);
    end

    // Debug access: write, stalled handshake, response, capture of the response.
    ir_to(5'b10001);
    expect_scan("dmi_first_capture", 41, dmi_word(5'd3, 34'h0_1234_5678, 2'b10), 64'h0);
    check("req_valid_up", 64'(dmi.dtm_req_valid), 1);
    check("req_bits", 64'(dmi.dtm_req_bits), dmi_word(5'd3, 34'h0_1234_5678, 2'b10));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, o);
      check("req_valid_hold", 64'(dmi.dtm_req_valid), 1);
      check("req_bits_hold", 64'(dmi.dtm_req_bits), dmi_word(5'd3, 34'h0_1234_5678, 2'b10));
    end
    dmi.dtm_req_ready = 1'b1;
    step(1'b0, 1'b0, o);
    dmi.dtm_req_ready = 1'b0;
    check("req_valid_drop", 64'(dmi.dtm_req_valid), 0);
    check("resp_ready_up", 64'(dmi.dtm_resp_ready), 1);
    dmi.dtm_resp_bits  = {34'h0_DEAD_BEEF, 2'b00};
    dmi.dtm_resp_valid = 1'b1;
    step(1'b0, 1'b0, o);
    dmi.dtm_resp_valid = 1'b0;
    check("resp_ready_drop", 64'(dmi.dtm_resp_ready), 0);
    expect_scan("dmi_resp_capture", 41, 64'h0, dmi_word(5'd3, 34'h0_DEAD_BEEF, 2'b00));
    check("nop_no_req", 64'(dmi.dtm_req_valid), 0);

    // Overlapping access while the first one waits for its response.
    expect_scan("dmi_pre_read", 41, dmi_word(5'd7, 34'h0, 2'b01), dmi_word(5'd3, 34'h0_DEAD_BEEF, 2'b00));
    check("read_req_valid", 64'(dmi.dtm_req_valid), 1);
    dmi.dtm_req_ready = 1'b1;
    step(1'b0, 1'b0, o);
    dmi.dtm_req_ready = 1'b0;
    expect_scan("dmi_busy_capture", 41, dmi_word(5'd9, 34'h55, 2'b10), dmi_word(5'd7, 34'h0_DEAD_BEEF, 2'b11));
    check("busy_no_req", 64'(dmi.dtm_req_valid), 0);
    ir_to(5'b10000);
    expect_scan("dtminfo_busy", 32, 64'h0, 64'h0000_0C51);
    check("wait_resp_ready", 64'(dmi.dtm_resp_ready), 1);
    dmi.dtm_resp_bits  = {34'h0_0000_0ABC, 2'b10};
    dmi.dtm_resp_valid = 1'b1;
    step(1'b0, 1'b0, o);
    dmi.dtm_resp_valid = 1'b0;
    ir_to(5'b10001);
    expect_scan("sticky_capture", 41, 64'h0, dmi_word(5'd7, 34'h0_0000_0ABC, 2'b11));
    ir_to(5'b10000);
    expect_scan("dtminfo_dmireset", 32, 64'h1_0000, 64'h0000_0C51);
    ir_to(5'b10001);
    expect_scan("cleared_capture", 41, 64'h0, dmi_word(5'd7, 34'h0_0000_0ABC, 2'b10));
    check("cleared_no_req", 64'(dmi.dtm_req_valid), 0);

    // Reset dropped mid-scan with a request pending.
    expect_scan("pre_reset_capture", 41, dmi_word(5'd1, 34'h77, 2'b10), dmi_word(5'd7, 34'h0_0000_0ABC, 2'b10));
    check("pre_reset_valid", 64'(dmi.dtm_req_valid), 1);
    step(1'b1, 1'b0, o);
    step(1'b0, 1'b0, o);
    step(1'b0, 1'b0, o);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, o);
    check("mid_shift_tdo_en", 64'(tdo_en), 1);
    dmi.dtm_resp_bits  = {34'h3_FFFF_FFFF, 2'b10};
    dmi.dtm_resp_valid = 1'b1;
    reset_n = 1'b0;
    #1;
    check("arst_tdo", 64'(tdo), 0);
    check("arst_tdo_en", 64'(tdo_en), 0);
    check("arst_req_valid", 64'(dmi.dtm_req_valid), 0);
    check("arst_req_bits", 64'(dmi.dtm_req_bits), 0);
    check("arst_resp_ready", 64'(dmi.dtm_resp_ready), 0);
    check("arst_tap_state", 64'(4'(dut.tap_state)), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, o);
      check("post_rst_resp_ready", 64'(dmi.dtm_resp_ready), 0);
    end
    dmi.dtm_resp_valid = 1'b0;
    go_idle();
    ir_to(5'b10001);
    expect_scan("post_rst_capture", 41, 64'h0, 64'h0);
    shift_ir(5'b00001, cap);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
